// File: rtl/wireshark_capture_writer.sv
// wireshark_capture_writer: packs an 8-bit Avalon-ST frame stream little-endian
// into 32-bit words and stores each frame in a circular capture RAM as one
// header word (error, truncated, byte count) followed by its data words.
// Ports:
//   clk, reset                    - single clock, synchronous active-high reset
//   enable                        - capture enable, sampled at SOP
//   snk_valid/ready/data/sop/eop/error - Avalon-ST byte sink
//   mem_address/byteenable/chipselect/write/writedata - RAM write port
//   rd_ptr                        - software consume pointer (next unread header)
//   wr_ptr                        - next free header slot, published after commit
//   frame_count, drop_count       - committed frames (wraps), dropped frames (saturates)
//   frame_done                    - one-cycle pulse per committed frame
module wireshark_capture_writer #(
    parameter int ADDR_W          = 12,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              snk_valid,
    output logic              snk_ready,
    input  logic [7:0]        snk_data,
    input  logic              snk_sop,
    input  logic              snk_eop,
    input  logic              snk_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [15:0]       frame_count,
    output logic [15:0]       drop_count,
    output logic              frame_done
);

    // Worst-case words a frame can occupy: all data words plus the header.
    localparam int unsigned NEED = (MAX_FRAME_BYTES + 3) / 4 + 1;

    typedef enum logic [2:0] {
        IDLE, DATA, TRUNC, SKIP, FLUSH, HDR, COMMIT
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] hdr;
    logic [ADDR_W-1:0] dptr;
    logic [31:0]       word;
    logic [2:0]        lanes;
    logic [15:0]       len;
    logic              err;
    logic              trunc;

    logic              accept;
    logic              start;
    logic              store;
    logic              ending;
    logic              drop;
    logic [ADDR_W-1:0] used;
    logic [ADDR_W-1:0] free;
    logic [31:0]       free_ext;
    logic              space_ok;
    logic [2:0]        lanes_cur;
    logic [2:0]        lanes_new;
    logic [15:0]       len_new;
    logic [31:0]       word_new;
    logic [ADDR_W-1:0] daddr;
    logic              wr_data;
    logic [3:0]        be;

    assign accept   = snk_valid & snk_ready;
    assign used     = wr_ptr - rd_ptr;
    // DEPTH-1-used is the bitwise complement in ADDR_W bits.
    assign free     = ~used;
    assign free_ext = 32'(free);
    assign space_ok = free_ext >= NEED;

    // A new frame starts with an empty word at hdr+1; otherwise continue.
    assign lanes_cur = (state == IDLE) ? 3'd0 : lanes;
    assign len_new   = ((state == IDLE) ? 16'd0 : len) + 16'd1;
    assign lanes_new = lanes_cur + {2'b00, store};
    assign daddr     = (state == IDLE) ? wr_ptr + ADDR_W'(1) : dptr;

    // Full words go out immediately; a frame end also drains a partial word,
    // so the FLUSH write appears in the cycle right after the last byte.
    assign wr_data = (lanes_new == 3'd4) || (ending && lanes_new != 3'd0);

    always_comb begin
        word_new = word;
        if (store)
            word_new[{lanes_cur[1:0], 3'b000} +: 8] = snk_data;
    end

    always_comb begin
        be = 4'b1111;
        case (lanes_new)
            3'd1:    be = 4'b0001;
            3'd2:    be = 4'b0011;
            3'd3:    be = 4'b0111;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        store      = 1'b0;
        ending     = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && snk_sop) begin
                    if (!enable) begin
                        state_next = snk_eop ? IDLE : SKIP;
                    end else if (!space_ok) begin
                        drop       = 1'b1;
                        state_next = snk_eop ? IDLE : SKIP;
                    end else begin
                        start = 1'b1;
                        store = 1'b1;
                        if (snk_eop) begin
                            ending     = 1'b1;
                            state_next = FLUSH;
                        end else if (len_new == 16'(MAX_FRAME_BYTES)) begin
                            state_next = TRUNC;
                        end else begin
                            state_next = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    if (snk_sop) begin
                        // Unexpected SOP ends the frame; the byte is dropped.
                        ending     = 1'b1;
                        state_next = FLUSH;
                    end else begin
                        store = 1'b1;
                        if (snk_eop) begin
                            ending     = 1'b1;
                            state_next = FLUSH;
                        end else if (len_new == 16'(MAX_FRAME_BYTES)) begin
                            state_next = TRUNC;
                        end
                    end
                end
            end
            TRUNC: begin
                if (accept && snk_eop) begin
                    ending     = 1'b1;
                    state_next = FLUSH;
                end
            end
            SKIP: begin
                if (accept && snk_eop)
                    state_next = IDLE;
            end
            FLUSH:   state_next = HDR;
            HDR:     state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            snk_ready      <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= 4'b0000;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= 32'd0;
            wr_ptr         <= '0;
            frame_count    <= 16'd0;
            drop_count     <= 16'd0;
            frame_done     <= 1'b0;
            hdr            <= '0;
            dptr           <= '0;
            word           <= 32'd0;
            lanes          <= 3'd0;
            len            <= 16'd0;
            err            <= 1'b0;
            trunc          <= 1'b0;
        end else begin
            state          <= state_next;
            snk_ready      <= (state_next == IDLE) || (state_next == DATA) ||
                              (state_next == TRUNC) || (state_next == SKIP);
            mem_write      <= 1'b0;
            mem_chipselect <= 1'b0;
            frame_done     <= 1'b0;

            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;

            if (start) begin
                hdr  <= wr_ptr;
                dptr <= wr_ptr + ADDR_W'(1);
                err  <= snk_error;
            end else if (accept && (state == DATA || state == TRUNC)) begin
                err <= err | snk_error | (state == DATA && snk_sop);
            end

            if (start)
                trunc <= 1'b0;
            if (state_next == TRUNC && state != TRUNC)
                trunc <= 1'b1;

            if (store) begin
                len  <= len_new;
                word <= word_new;
            end

            if (wr_data) begin
                mem_write      <= 1'b1;
                mem_chipselect <= 1'b1;
                mem_address    <= daddr;
                mem_byteenable <= be;
                mem_writedata  <= word_new;
                dptr           <= daddr + ADDR_W'(1);
                lanes          <= 3'd0;
            end else if (store) begin
                lanes <= lanes_new;
            end

            if (state == FLUSH) begin
                mem_write      <= 1'b1;
                mem_chipselect <= 1'b1;
                mem_address    <= hdr;
                mem_byteenable <= 4'b1111;
                mem_writedata  <= {err, trunc, 14'd0, len};
            end

            // Registered here so the new pointer is visible in COMMIT.
            if (state == HDR) begin
                wr_ptr      <= dptr;
                frame_count <= frame_count + 16'd1;
                frame_done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wireshark_capture_writer.sv
// tb_wireshark_capture_writer: directed frames with hand-computed RAM
// contents, header words, pointers and counters.
module tb_wireshark_capture_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        snk_valid = 1'b0;
    logic        snk_ready;
    logic [7:0]  snk_data = 8'd0;
    logic        snk_sop = 1'b0;
    logic        snk_eop = 1'b0;
    logic        snk_error = 1'b0;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [11:0] rd_ptr = 12'd0;
    logic [11:0] wr_ptr;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [4096];
    logic [3:0]  be_log [4096];
    int          wcount = 0;
    int          dcount = 0;
    int          cs_bad = 0;
    logic [11:0] last_addr = 12'd0;

    wireshark_capture_writer dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .snk_data       (snk_data),
        .snk_sop        (snk_sop),
        .snk_eop        (snk_eop),
        .snk_error      (snk_error),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .rd_ptr         (rd_ptr),
        .wr_ptr         (wr_ptr),
        .frame_count    (frame_count),
        .drop_count     (drop_count),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 4; i++)
                if (mem_byteenable[i])
                    ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            be_log[mem_address] <= mem_byteenable;
            wcount <= wcount + 1;
            last_addr <= mem_address;
        end
        if (frame_done)
            dcount <= dcount + 1;
        if (mem_chipselect !== mem_write)
            cs_bad <= cs_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic s, input logic e,
                       input logic er, output int w);
        w = 0;
        @(negedge clk);
        while (!snk_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (w >= 64)
            check("ready_timeout", {31'd0, snk_ready}, 32'd1);
        snk_valid = 1'b1;
        snk_data  = d;
        snk_sop   = s;
        snk_eop   = e;
        snk_error = er;
        @(posedge clk);
    endtask

    task automatic idle_bus();
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        snk_error = 1'b0;
    endtask

    task automatic send_frame(input int n, input int err_at, output int waits);
        int w;
        waits = 0;
        for (int i = 0; i < n; i++) begin
            put(8'(i), i == 0, i == n - 1, i == err_at, w);
            waits += w;
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (dcount == prev && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(dcount - prev), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_bus();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int w;
        int w0;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, snk_ready}, 32'd0);
        check("rst_write", {31'd0, mem_write}, 32'd0);
        check("rst_addr", {20'd0, mem_address}, 32'd0);
        check("rst_wdata", mem_writedata, 32'd0);
        check("rst_wr_ptr", {20'd0, wr_ptr}, 32'd0);
        check("rst_counts", {frame_count, drop_count}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, snk_ready}, 32'd1);

        // 64-byte frame with cycle-level commit timing
        d0 = dcount;
        send_frame(64, -1, w);
        check("t1_ready_T1", {31'd0, snk_ready}, 32'd0);
        check("t1_write_T1", {mem_write, 19'd0, mem_address}, {1'b1, 19'd0, 12'd16});
        @(negedge clk);
        check("t1_hdr_T2", {mem_write, 3'd0, mem_byteenable, 12'd0, mem_address},
              {1'b1, 3'd0, 4'hF, 12'd0, 12'd0});
        check("t1_hdr_data", mem_writedata, 32'h00000040);
        @(negedge clk);
        check("t1_done_T3", {31'd0, frame_done}, 32'd1);
        check("t1_wr_ptr_T3", {20'd0, wr_ptr}, 32'd17);
        check("t1_ready_T3", {31'd0, snk_ready}, 32'd0);
        @(negedge clk);
        check("t1_ready_T4", {31'd0, snk_ready}, 32'd1);
        check("t1_done_T4", {31'd0, frame_done}, 32'd0);
        check("t1_word1", ram[1], 32'h03020100);
        check("t1_word16", ram[16], 32'h3F3E3D3C);
        check("t1_hdr", ram[0], 32'h00000040);
        check("t1_one_pulse", 32'(dcount - d0), 32'd1);
        check("t1_count", {16'd0, frame_count}, 32'd1);

        // 61-byte frame: partial last word
        do_reset();
        send_frame(61, -1, w);
        wait_done(dcount);
        check("t2_last_be", {28'd0, be_log[16]}, 32'h1);
        check("t2_last_byte", {24'd0, ram[16][7:0]}, 32'h3C);
        check("t2_hdr", ram[0], 32'd61);
        check("t2_wr_ptr", {20'd0, wr_ptr}, 32'd17);

        // Single-byte SOP+EOP frame
        do_reset();
        put(8'h5A, 1'b1, 1'b1, 1'b0, w);
        @(negedge clk);
        idle_bus();
        wait_done(dcount - 0);
        check("t3_hdr", ram[0], 32'd1);
        check("t3_byte", {24'd0, ram[1][7:0]}, 32'h5A);
        check("t3_be", {28'd0, be_log[1]}, 32'h1);
        check("t3_wr_ptr", {20'd0, wr_ptr}, 32'd2);

        // Fill to 4090: ten 1518-byte frames (381 words) + one 1116-byte (280)
        do_reset();
        for (int k = 0; k < 10; k++) begin
            rd_ptr = wr_ptr;
            d0 = dcount;
            send_frame(1518, -1, w);
            wait_done(d0);
            if (k == 0)
                check("max_len_hdr", ram[0], 32'h000005EE);
        end
        rd_ptr = wr_ptr;
        d0 = dcount;
        send_frame(1116, -1, w);
        wait_done(d0);
        check("fill_wr_ptr", {20'd0, wr_ptr}, 32'd4090);

        // Wrap-around 40-byte frame
        rd_ptr = 12'd4000;
        d0 = dcount;
        send_frame(40, -1, w);
        wait_done(d0);
        check("wrap_hdr", ram[4090], 32'd40);
        check("wrap_w4091", ram[4091], 32'h03020100);
        check("wrap_w4095", ram[4095], 32'h13121110);
        check("wrap_w0", ram[0], 32'h17161514);
        check("wrap_w4", ram[4], 32'h27262524);
        check("wrap_wr_ptr", {20'd0, wr_ptr}, 32'd5);
        check("wrap_count", {16'd0, frame_count}, 32'd12);

        // enable low: frame ignored, not counted as a drop
        enable = 1'b0;
        w0 = wcount;
        send_frame(8, -1, w);
        repeat (4) @(negedge clk);
        enable = 1'b1;
        check("dis_drop", {16'd0, drop_count}, 32'd0);
        check("dis_writes", 32'(wcount - w0), 32'd0);
        check("dis_count", {16'd0, frame_count}, 32'd12);

        // Full buffer: free = 379 < 381
        rd_ptr = 12'd385;
        w0 = wcount;
        send_frame(8, -1, w);
        repeat (6) @(negedge clk);
        check("full_drop", {16'd0, drop_count}, 32'd1);
        check("full_writes", 32'(wcount - w0), 32'd0);
        check("full_ready_held", 32'(w), 32'd0);
        check("full_wr_ptr", {20'd0, wr_ptr}, 32'd5);
        rd_ptr = 12'd387;
        d0 = dcount;
        send_frame(8, -1, w);
        wait_done(d0);
        check("room_hdr", ram[5], 32'd8);
        check("room_w7", ram[7], 32'h07060504);
        check("room_wr_ptr", {20'd0, wr_ptr}, 32'd8);

        // 2000-byte frame, error on byte 10, truncated at 1518
        rd_ptr = 12'd8;
        w0 = wcount;
        d0 = dcount;
        send_frame(2000, 10, w);
        wait_done(d0);
        check("trunc_hdr", ram[8], 32'hC00005EE);
        check("trunc_w9", ram[9], 32'h03020100);
        check("trunc_last", {16'd0, ram[388][15:0]}, 32'h0000EDEC);
        check("trunc_last_be", {28'd0, be_log[388]}, 32'h3);
        check("trunc_writes", 32'(wcount - w0), 32'd381);
        check("trunc_wr_ptr", {20'd0, wr_ptr}, 32'd389);

        // Mid-frame SOP after 5 bytes
        rd_ptr = 12'd389;
        d0 = dcount;
        for (int i = 0; i < 5; i++)
            put(8'(i), i == 0, 1'b0, 1'b0, w);
        put(8'hAA, 1'b1, 1'b0, 1'b0, w);
        @(negedge clk);
        idle_bus();
        wait_done(d0);
        check("sop_hdr", ram[389], 32'h80000005);
        check("sop_w390", ram[390], 32'h03020100);
        check("sop_tail", {24'd0, ram[391][7:0]}, 32'h04);
        check("sop_tail_be", {28'd0, be_log[391]}, 32'h1);
        check("sop_wr_ptr", {20'd0, wr_ptr}, 32'd392);

        // Reset during DATA: frame abandoned, no header
        rd_ptr = 12'd392;
        w0 = wcount;
        d0 = dcount;
        for (int i = 0; i < 10; i++)
            put(8'(i), i == 0, 1'b0, 1'b0, w);
        @(negedge clk);
        idle_bus();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_wr_ptr", {20'd0, wr_ptr}, 32'd0);
        check("rstmid_count", {16'd0, frame_count}, 32'd0);
        check("rstmid_writes", 32'(wcount - w0), 32'd2);
        check("rstmid_last", {20'd0, last_addr}, 32'd394);
        check("rstmid_done", 32'(dcount - d0), 32'd0);

        check("chipselect", 32'(cs_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wireshark_capture_writer.md
# wireshark_capture_writer

Packet-capture writer feeding the 4096×32 on-chip capture RAM through its write port. Accepts an 8-bit Avalon-ST byte stream from the Ethernet receive path and packs bytes little-endian into 32-bit words. Stores each frame in a circular buffer as one header word followed by its data words. The Nios software drains frames and returns space by advancing `rd_ptr`.

## Interface
- `ADDR_W`, 12: word-address width; buffer depth is DEPTH = 2^ADDR_W.
- `MAX_FRAME_BYTES`, 1518: longest frame stored; excess bytes are truncated.
- `clk`  in  1: single clock for all logic.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: capture enable, sampled at SOP only.
- `snk_valid`  in  1: byte valid.
- `snk_ready`  out  1: byte accepted when valid & ready.
- `snk_data`  in  8: byte.
- `snk_sop`  in  1: first byte of frame.
- `snk_eop`  in  1: last byte of frame.
- `snk_error`  in  1: MAC error flag; sticky per frame, any byte.
- `mem_address`  out  ADDR_W: word address.
- `mem_byteenable`  out  4: lane enables; lane0 = bits 7:0.
- `mem_chipselect`  out  1: equals `mem_write`.
- `mem_write`  out  1: one-cycle write strobe; the RAM has no waitrequest.
- `mem_writedata`  out  32: packed word.
- `rd_ptr`  in  ADDR_W: software consume pointer (next unread header).
- `wr_ptr`  out  ADDR_W: next free header slot; published only after a frame's header is written.
- `frame_count`  out  16: frames committed; wraps.
- `drop_count`  out  16: frames dropped for lack of space; saturates at 0xFFFF.
- `frame_done`  out  1: one-cycle pulse per committed frame.

## Operation
- Header word: bit31 = error, bit30 = truncated, bits29:16 = 0, bits15:0 = stored byte count.
- Header is written at `hdr = wr_ptr`. Data starts at `hdr+1`. All addresses are mod DEPTH.
- Space check at SOP:
  - used = (`wr_ptr` − `rd_ptr`) mod DEPTH; free = DEPTH−1−used.
  - NEED = ceil(MAX_FRAME_BYTES/4)+1, which is 381 with defaults.
  - Frame is accepted only if free ≥ NEED.
- States:
  - IDLE: `snk_ready`=1.
    - Accepted byte without SOP: discarded.
    - SOP with `enable`=0: go to SKIP (no count).
    - SOP with insufficient space: go to SKIP and increment `drop_count`.
    - SOP otherwise: latch `hdr`, put the byte in lane0, len=1, go to DATA. If EOP is also set, go to FLUSH.
  - DATA: `snk_ready`=1. Each accepted byte fills the next lane; len increments.
    - After lane3 fills, the full word is written (byteenable 1111) in the next cycle; the data pointer increments.
    - Byte with EOP: go to FLUSH.
    - len reaching MAX_FRAME_BYTES without EOP: set truncated, go to TRUNC.
    - SOP while in DATA: set error, treat that byte as the terminating byte but do not store it, then go to FLUSH.
  - TRUNC: `snk_ready`=1; discard bytes until EOP, then go to FLUSH. A partial word pending when truncation hits is retained.
  - SKIP: `snk_ready`=1; discard until EOP, then go to IDLE. SOP+EOP on a single byte returns directly to IDLE.
  - FLUSH: `snk_ready`=0.
    - If lanes are pending, write them with byteenable = the filled lanes (1 lane → 0001, 2 → 0011, 3 → 0111, 4 → 1111).
    - With no pending lanes, no write occurs.
    - Go to HDR.
  - HDR: `snk_ready`=0. Write the header at `hdr` with byteenable 1111, then go to COMMIT.
  - COMMIT: `snk_ready`=0.
    - `wr_ptr` ← next word after the last data word.
    - `frame_count`+1; `frame_done`=1.
    - Go to IDLE.
- Unwritten lanes of a partial word are undefined in memory; software uses the header length.
- `enable` falling mid-frame has no effect on that frame.

## Timing
- Reset values:
  - `snk_ready` = 0.
  - `mem_write`, `mem_chipselect`, `mem_address`, `mem_byteenable`, `mem_writedata` = 0.
  - `wr_ptr` = 0, `frame_count` = 0, `drop_count` = 0, `frame_done` = 0.
  - State = IDLE.
- `snk_ready` rises the first cycle after `reset` deasserts.
- All `mem_*` outputs are registered. A data write appears 1 cycle after the byte completing the word is accepted.
- EOP accepted at cycle T:
  - Flush write at T+1 (if any lanes are pending).
  - Header write at T+2.
  - `wr_ptr`, `frame_count` and `frame_done` updated at T+3.
  - `snk_ready`=0 during T+1..T+3; ready again at T+4.
- Max one memory write per cycle. Full-word writes in DATA never coincide with FLUSH or HDR writes.
- The space check uses `rd_ptr` as sampled in the SOP cycle. Later `rd_ptr` changes only add space.
- Reset mid-frame: the frame is abandoned, no header is written, and `wr_ptr` returns to 0.

## Test plan
- 64-byte frame 0x00..0x3F with `rd_ptr`=0:
  - Words 1..16 = 0x03020100 … 0x3F3E3D3C.
  - Word 0 = 0x00000040; `wr_ptr`=17; one `frame_done` pulse.
- 61-byte frame:
  - Last data write has byteenable 0001.
  - Header length = 61; `wr_ptr`=17.
- Wrap-around:
  - Setup: `wr_ptr` at 4090 with `rd_ptr`=4000.
  - Send a 40-byte frame.
  - Header at 4090; data at 4091..4095 then 0..4; `wr_ptr`=5.
- Full buffer:
  - Setup: `rd_ptr` = `wr_ptr`+380 mod DEPTH, so free = 379.
  - Send a frame: dropped, `drop_count`=1, no `mem_write`, ready held 1.
  - Advance `rd_ptr` by 2: the next frame is stored.
- 2000-byte frame with `snk_error` on byte 10:
  - Header = 0xC00005EE (error, truncated, length 1518).
  - Data words 1..380 written; `wr_ptr` = `hdr`+381.
- Mid-frame SOP after 5 bytes:
  - Header = 0x80000005.
  - Assert `reset` during the next frame's DATA state: `wr_ptr`=0 and no header write for that frame.
